flag_hazard_ctrl: RTL and testbench
===================================

// Module: flag_hazard_ctrl
// PURPOSE
//  Owns the architectural NZCV register. Resolves ARM condition codes early, in Decode, against committed flags.
//  Scoreboards in-flight flag writers (NZ group, CV group) and stalls Decode until the flags it reads are committed.
//  Sits between Decode issue and the Execute/commit flag-update path; lets conditional branches resolve one stage early.
// PARAMETERS
//  MAX_INFLIGHT  3  max uncommitted flag writers tracked per group; counter width CW = $clog2(MAX_INFLIGHT+1)
// PORTS
//  clk            in   1  rising-edge clock
//  reset          in   1  synchronous, active-high reset
//  DecValid       in   1  Decode holds a valid instruction
//  DecCond        in   4  cond field of Decode instruction
//  DecFlagsWrite  in   2  [1]=writes NZ, [0]=writes CV if it executes
//  CommitValid    in   1  oldest in-flight instruction commits this cycle
//  CommitFlagsWrite in 2  FlagsWrite of committing instruction
//  CommitCondEx   in   1  committing instruction passed its condition
//  CommitALUFlags in   4  {N,Z,C,V} from ALU for committing instruction
//  Flush          in   1  kill all issued-but-uncommitted instructions and Decode
//  Stall          out  1  hold Decode (combinational)
//  Issue          out  1  DecValid & ~Stall & ~Flush (combinational)
//  EarlyCondEx    out  1  condition result for Decode instruction; meaningful only when Issue=1
//  Flags          out  4  committed {N,Z,C,V} (registered)
//  ProtoErr       out  1  sticky: commit with a zero scoreboard counter
// BEHAVIOUR
//  Reset: Flags=0, CntNZ=CntCV=0, ProtoErr=0. Stall/Issue/EarlyCondEx follow combinationally (Issue=0 if DecValid=0).
//  Flags read per cond:
//   EQ/NE: Z.  CS/CC: C.  MI/PL: N.  VS/VC: V.  HI/LS: C,Z.
//   GE/LT: N,V.  GT/LE: N,Z,V.  AL(1110), 1111: none.
//  Group use: NeedNZ if N or Z read; NeedCV if C or V read.
//  EarlyCondEx: standard ARM table on Flags; AL=1; 1111=0 (never x).
//  Stall = DecValid & ((NeedNZ & CntNZ!=0) | (NeedCV & CntCV!=0)
//          | (DecFlagsWrite[1] & CntNZ==MAX_INFLIGHT) | (DecFlagsWrite[0] & CntCV==MAX_INFLIGHT)).
//  Counters, per group g (NZ bit1, CV bit0):
//   inc = Issue & DecFlagsWrite[g]; dec = CommitValid & CommitFlagsWrite[g].
//   inc&dec -> unchanged; inc -> +1; dec -> -1.
//   dec with Cnt==0 -> stays 0; ProtoErr<=1.
//   Flush: Cnt<=0 next cycle regardless of inc/dec (commit same cycle still updates Flags).
//  Flag commit (takes effect next edge, no bypass to EarlyCondEx same cycle):
//   CommitValid & CommitCondEx & CommitFlagsWrite[1] -> Flags[3:2]<=CommitALUFlags[3:2].
//   CommitValid & CommitCondEx & CommitFlagsWrite[0] -> Flags[1:0]<=CommitALUFlags[1:0].
//   CommitCondEx=0 -> Flags held, but counter still decrements.
//  Latency: a reader stalled on a writer issues the cycle after that writer commits (1-cycle bubble minimum).
//  Reset asserted mid-operation overrides Flush, commit and issue; all state returns to reset values.
//  ProtoErr clears only on reset.
// TESTING
//  1 reset, DecValid=1 DecCond=EQ, counters 0, Flags=0 -> Stall=0, Issue=1, EarlyCondEx=0.
//  2 issue ADDS (FW=11, AL), next cycle BEQ -> Stall=1.
//    commit ALUFlags=0100 CondEx=1 -> Flags=0100; BEQ issues next cycle with EarlyCondEx=1.
//  3 CntNZ=1, Decode BCS (reads C only) -> Stall=0.
//    Decode BGT (reads N,Z,V) -> Stall=1.
//  4 fill NZ to MAX_INFLIGHT=3 writers; 4th NZ writer (AL) -> Stall=1.
//    same cycle issue+commit of NZ writers -> CntNZ unchanged.
//  5 CntNZ=2, Flush with commit(FW=10, CondEx=0) -> CntNZ=0 next cycle, Flags unchanged, Issue=0 during Flush.
//  6 CommitValid FW=01 with CntCV=0 -> CntCV stays 0, ProtoErr=1 until reset; DecCond=1111 -> EarlyCondEx=0.

Source files
------------

// File: rtl/flag_hazard_ctrl.sv
// flag_hazard_ctrl: committed NZCV register, early condition resolution in Decode,
// and per-group (NZ, CV) scoreboarding of in-flight flag writers.
module flag_hazard_ctrl #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       DecValid,
  input  logic [3:0] DecCond,
  input  logic [1:0] DecFlagsWrite,
  input  logic       CommitValid,
  input  logic [1:0] CommitFlagsWrite,
  input  logic       CommitCondEx,
  input  logic [3:0] CommitALUFlags,
  input  logic       Flush,
  output logic       Stall,
  output logic       Issue,
  output logic       EarlyCondEx,
  output logic [3:0] Flags,
  output logic       ProtoErr
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);
  // Indexed by DecCond[3:1]: which cond pairs read N/Z and which read C/V.
  localparam logic [7:0] NZ_USE = 8'b0111_0101;
  localparam logic [7:0] CV_USE = 8'b0111_1010;
  logic [1:0][CW-1:0] cnt;
  logic [1:0] need, busy, full, inc, dec, under;
  logic [7:0] base;
  logic n, z, c, v;
  always_comb begin
    {n, z, c, v} = Flags;
    // Even cond of each pair; the odd one is its inverse (1110 -> 1, 1111 -> 0).
    base = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
    EarlyCondEx = base[DecCond[3:1]] ^ DecCond[0];
    need = {NZ_USE[DecCond[3:1]], CV_USE[DecCond[3:1]]};
    busy = {cnt[1] != '0, cnt[0] != '0};
    full = {cnt[1] == CMAX, cnt[0] == CMAX};
    Stall = DecValid & ((|(need & busy)) | (|(DecFlagsWrite & full)));
    Issue = DecValid & ~Stall & ~Flush;
    inc = {2{Issue}} & DecFlagsWrite;
    dec = {2{CommitValid}} & CommitFlagsWrite;
    under = dec & ~busy;
  end
  for (genvar g = 0; g < 2; g++) begin : grp
    always_ff @(posedge clk)
      if (reset || Flush) cnt[g] <= '0;
      else if (inc[g] && !dec[g]) cnt[g] <= cnt[g] + CW'(1);
      else if (dec[g] && !inc[g] && busy[g]) cnt[g] <= cnt[g] - CW'(1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      Flags <= '0;
      ProtoErr <= 1'b0;
    end else begin
      if (CommitValid && CommitCondEx && CommitFlagsWrite[1]) Flags[3:2] <= CommitALUFlags[3:2];
      if (CommitValid && CommitCondEx && CommitFlagsWrite[0]) Flags[1:0] <= CommitALUFlags[1:0];
      ProtoErr <= ProtoErr | (|under);
    end
endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// tb_flag_hazard_ctrl: directed tests of flag_hazard_ctrl with hand-computed expectations.
module tb_flag_hazard_ctrl;
  logic clk = 0, reset = 1, DecValid = 0, CommitValid = 0, CommitCondEx = 0, Flush = 0;
  logic [3:0] DecCond = 0, CommitALUFlags = 0;
  logic [1:0] DecFlagsWrite = 0, CommitFlagsWrite = 0;
  logic Stall, Issue, EarlyCondEx, ProtoErr;
  logic [3:0] Flags;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  flag_hazard_ctrl #(.MAX_INFLIGHT(3)) dut (
    .clk(clk), .reset(reset), .DecValid(DecValid), .DecCond(DecCond),
    .DecFlagsWrite(DecFlagsWrite), .CommitValid(CommitValid),
    .CommitFlagsWrite(CommitFlagsWrite), .CommitCondEx(CommitCondEx),
    .CommitALUFlags(CommitALUFlags), .Flush(Flush), .Stall(Stall), .Issue(Issue),
    .EarlyCondEx(EarlyCondEx), .Flags(Flags), .ProtoErr(ProtoErr)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic dec_in(input logic vld, input logic [3:0] cond, input logic [1:0] fw);
    DecValid = vld; DecCond = cond; DecFlagsWrite = fw;
  endtask
  task automatic com_in(input logic vld, input logic [1:0] fw, input logic cx, input logic [3:0] alu);
    CommitValid = vld; CommitFlagsWrite = fw; CommitCondEx = cx; CommitALUFlags = alu;
  endtask
  task automatic test_reset;
    reset = 1; dec_in(1, 4'b0000, 2'b00); com_in(0, 0, 0, 0);
    step; reset = 0; #1;
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", Flags); end
    total++; if (ProtoErr !== 1'b0) begin bad++; $display("FAIL reset_proto got=%b want=0", ProtoErr); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", Stall); end
    total++; if (Issue !== 1'b1) begin bad++; $display("FAIL reset_issue got=%b want=1", Issue); end
    total++; if (EarlyCondEx !== 1'b0) begin bad++; $display("FAIL reset_ece got=%b want=0", EarlyCondEx); end
    DecValid = 0; #1;
    total++; if (Issue !== 1'b0) begin bad++; $display("FAIL novalid_issue got=%b want=0", Issue); end
  endtask
  task automatic test_adds_beq;
    dec_in(1, 4'b1110, 2'b11); #1;
    total++; if (Issue !== 1'b1) begin bad++; $display("FAIL adds_issue got=%b want=1", Issue); end
    step;
    dec_in(1, 4'b0000, 2'b00); #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL beq_stall got=%b want=1", Stall); end
    total++; if (Issue !== 1'b0) begin bad++; $display("FAIL beq_issue_stalled got=%b want=0", Issue); end
    com_in(1, 2'b11, 1, 4'b0100); #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL beq_stall_commit got=%b want=1", Stall); end
    step;
    com_in(0, 0, 0, 0); #1;
    total++; if (Flags !== 4'b0100) begin bad++; $display("FAIL adds_flags got=%b want=0100", Flags); end
    total++; if (Issue !== 1'b1) begin bad++; $display("FAIL beq_issue got=%b want=1", Issue); end
    total++; if (EarlyCondEx !== 1'b1) begin bad++; $display("FAIL beq_ece got=%b want=1", EarlyCondEx); end
    step;
  endtask
  task automatic test_group_split;
    dec_in(1, 4'b1110, 2'b10); step;
    dec_in(1, 4'b0010, 2'b00); #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL bcs_stall got=%b want=0", Stall); end
    total++; if (EarlyCondEx !== 1'b0) begin bad++; $display("FAIL bcs_ece got=%b want=0", EarlyCondEx); end
    dec_in(1, 4'b1100, 2'b00); #1;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL bgt_stall got=%b want=1", Stall); end
    dec_in(0, 0, 0); com_in(1, 2'b10, 1, 4'b0000); step;
    com_in(0, 0, 0, 0); #1;
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL split_flags got=%b want=0000", Flags); end
  endtask
  task automatic test_full;
    dec_in(1, 4'b1110, 2'b10);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (Issue !== 1'b1) begin bad++; $display("FAIL fill_issue%0d got=%b want=1", i, Issue); end
      step;
    end
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b want=1", Stall); end
    dec_in(0, 0, 0); com_in(1, 2'b10, 0, 4'b1111); step;
    dec_in(1, 4'b1110, 2'b10); #1;
    total++; if (Issue !== 1'b1) begin bad++; $display("FAIL swap_issue got=%b want=1", Issue); end
    step;
    com_in(0, 0, 0, 0); #1;
    total++; if (Issue !== 1'b1) begin bad++; $display("FAIL after_swap_issue got=%b want=1", Issue); end
    step;
    total++; if (Stall !== 1'b1) begin bad++; $display("FAIL refull_stall got=%b want=1", Stall); end
    dec_in(0, 0, 0); com_in(1, 2'b10, 0, 4'b1111);
    step; step; step;
    com_in(0, 0, 0, 0); dec_in(1, 4'b0000, 2'b00); #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL drain_stall got=%b want=0", Stall); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL drain_flags got=%b want=0000", Flags); end
  endtask
  task automatic test_flush;
    dec_in(1, 4'b1110, 2'b10); step; step;
    Flush = 1; com_in(1, 2'b10, 0, 4'b1111); #1;
    total++; if (Issue !== 1'b0) begin bad++; $display("FAIL flush_issue got=%b want=0", Issue); end
    step;
    Flush = 0; com_in(0, 0, 0, 0); dec_in(1, 4'b0000, 2'b00); #1;
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL flush_cnt_stall got=%b want=0", Stall); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL flush_flags got=%b want=0000", Flags); end
    total++; if (ProtoErr !== 1'b0) begin bad++; $display("FAIL flush_proto got=%b want=0", ProtoErr); end
  endtask
  task automatic test_cond_table;
    logic [3:0] fl [3] = '{4'b1001, 4'b0110, 4'b0010};
    logic [15:0] ex [3] = '{16'h565A, 16'h66A5, 16'h55A6};
    for (int k = 0; k < 3; k++) begin
      dec_in(1, 4'b1110, 2'b11); step;
      dec_in(0, 0, 0); com_in(1, 2'b11, 1, fl[k]); step;
      com_in(0, 0, 0, 0);
      for (int cc = 0; cc < 16; cc++) begin
        dec_in(1, 4'(cc), 2'b00); #1;
        total++;
        if (Issue !== 1'b1 || EarlyCondEx !== ex[k][cc]) begin
          bad++; $display("FAIL cond flags=%b cond=%0d issue=%b ece=%b want ece=%b", fl[k], cc, Issue, EarlyCondEx, ex[k][cc]);
        end
      end
    end
    total++; if (ProtoErr !== 1'b0) begin bad++; $display("FAIL cond_proto got=%b want=0", ProtoErr); end
  endtask
  task automatic test_proto;
    dec_in(1, 4'b1111, 2'b00); com_in(1, 2'b01, 1, 4'b0011); #1;
    total++; if (EarlyCondEx !== 1'b0) begin bad++; $display("FAIL nv_ece got=%b want=0", EarlyCondEx); end
    step;
    com_in(0, 0, 0, 0); dec_in(1, 4'b0010, 2'b00); #1;
    total++; if (ProtoErr !== 1'b1) begin bad++; $display("FAIL proto_set got=%b want=1", ProtoErr); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL proto_cnt_stall got=%b want=0", Stall); end
    total++; if (Flags !== 4'b0011) begin bad++; $display("FAIL proto_flags got=%b want=0011", Flags); end
    step; step;
    total++; if (ProtoErr !== 1'b1) begin bad++; $display("FAIL proto_sticky got=%b want=1", ProtoErr); end
    reset = 1; dec_in(1, 4'b1110, 2'b11); com_in(1, 2'b11, 1, 4'b1111); Flush = 1;
    step;
    reset = 0; Flush = 0; com_in(0, 0, 0, 0); dec_in(1, 4'b0000, 2'b00); #1;
    total++; if (ProtoErr !== 1'b0) begin bad++; $display("FAIL reset2_proto got=%b want=0", ProtoErr); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL reset2_flags got=%b want=0000", Flags); end
    total++; if (Stall !== 1'b0) begin bad++; $display("FAIL reset2_stall got=%b want=0", Stall); end
  endtask
  initial begin
    test_reset;
    test_adds_beq;
    test_group_split;
    test_full;
    test_flush;
    test_cond_table;
    test_proto;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
